rr_flow_arbiter: RTL and testbench
==================================

Name: rr_flow_arbiter

Overview:
- Parametrised round-robin output-port arbiter for the NoC router; successor to the fixed 5-input arbiter.
- Arbitrates NUM_PORTS input-channel requests for one output link.
- Drives the crossbar select and the RTS/DCTS flow-control handshake toward the downstream router.
- Adds packet-level locking (grant held until tail flit) and fair rotating priority in place of a fixed priority chain.

Parameters:
NUM_PORTS, 5, number of requesting input channels (2..16); index 0 = N, 1 = E, 2 = W, 3 = S, 4 = L at the default.
IDX_W, $clog2(NUM_PORTS), width of the owner index and the round-robin pointer.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req  in  NUM_PORTS  per-channel request; head-of-line flit valid and routed to this output
tail  in  NUM_PORTS  per-channel flag: head-of-line flit is a tail (or single-flit) flit
dcts  in  1  downstream clear-to-send
grant  out  NUM_PORTS  one-hot pulse; owner's flit is consumed this cycle
xbar_sel  out  NUM_PORTS  one-hot crossbar select of the current owner; all-zero when idle
rts  out  1  registered request-to-send to the downstream router
busy  out  1  high whenever an owner is held (state != IDLE)

Behaviour:
- Reset (sync, rst=1 at posedge clk):
  - state = IDLE, rts = 0, owner = 0, rr_ptr = 0.
  - grant = 0, xbar_sel = 0, busy = 0 from the cycle after reset and during reset.
- States:
  - IDLE: rts = 0, xbar_sel = 0.
  - SEND: rts = 1, xbar_sel = onehot(owner).
  - GAP: rts = 0, xbar_sel = onehot(owner), owner held.
- Arbitration function: first asserted req scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_PORTS.
  - Pure combinational.
  - Applied only when leaving IDLE, or when leaving GAP after a tail transfer.
- IDLE:
  - If any req, owner <= winner and state <= SEND. rts rises the next cycle, i.e. 1 cycle after req.
  - Otherwise stay in IDLE.
- SEND:
  - Transfer happens when rts & dcts: grant[owner] = 1 combinationally in that cycle, and state <= GAP.
  - If dcts = 0, hold SEND with rts = 1. No timeout.
  - Record xfer_tail <= tail[owner] at the transfer.
- GAP: exactly one cycle with rts low, matching the existing handshake.
  - If xfer_tail = 0: owner held; state <= SEND if req[owner], else stay GAP (wait for the next body flit).
  - If xfer_tail = 1: rr_ptr <= owner+1 (mod NUM_PORTS, wrap from NUM_PORTS-1 to 0).
    - Then rearbitrate using the new pointer: any req -> owner <= winner, SEND; none -> IDLE.
- Non-owner req and tail are ignored while an owner is held.
- grant is never asserted outside SEND, and never more than one bit at a time.
- rst during SEND or GAP: the flit is abandoned, no grant that cycle, state returns to IDLE.
- dcts while rts = 0: no effect.

Optional Feature:
- Macro: ARB_PKT_LOCK_EN.
- Defined: packet locking exactly as above.
- Undefined:
  - tail is ignored and every transfer is treated as xfer_tail = 1.
  - Arbitration rotates after every flit (flit-level round-robin).
  - The tail port remains in the port list but is unused.

Decomposition:
- Package noc_arb_pkg holds:
  - typedef arb_state_e {IDLE, SEND, GAP}
  - localparam default NUM_PORTS = 5
  - port-index constants PORT_N/E/W/S/L.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req vector and pointer.
  - Outputs: winner index and a valid flag.
  - Parametrised by NUM_PORTS.

Test Plan:
1. Reset then idle: rst 2 cycles, req = 0 -> rts = 0, grant = 0, xbar_sel = 0, busy = 0 indefinitely.
2. Single 3-flit packet on port 2, dcts = 1: req[2] = 1, tail asserted on the 3rd flit.
   - rts toggles 1,0,1,0,1.
   - grant = 5'b00100 on 3 cycles.
   - xbar_sel = 5'b00100 throughout.
   - IDLE after the tail; rr_ptr = 3.
3. Backpressure: owner port 0, dcts = 0 for 7 cycles then 1.
   - rts held 1 for 8 cycles.
   - grant[0] only in the dcts = 1 cycle.
4. Fairness: all 5 req held high, single-flit packets (tail = 1).
   - Grant order 0,1,2,3,4,0.
   - Pointer wraps from 4 to 0.
5. Lock check (ARB_PKT_LOCK_EN): port 3 mid-packet while port 1 requests.
   - No grant to port 1 until port 3's tail has transferred; then port 4 is skipped (no req) and port 1 wins.
6. Mid-operation reset: rst asserted in SEND with dcts = 1 -> grant = 0 that cycle, IDLE next, rts = 0. Also repeat scenario 4 with NUM_PORTS = 3 and with ARB_PKT_LOCK_EN undefined: packets interleave flit by flit.

Source files
------------

// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC output-port arbiter.
// Port indices follow the 5-port router layout (N, E, W, S, L).
package noc_arb_pkg;

  localparam int DEFAULT_NUM_PORTS = 5;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_flow_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first asserted request found
// when scanning from i_ptr upward, wrapping modulo NUM_PORTS.
module rr_pick
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  output logic [IDX_W-1:0]     o_winner,
  output logic                 o_valid
);

  logic [IDX_W-1:0] w_idx;

  // Scan from the farthest offset down so the nearest request to the pointer wins.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_idx = IDX_W'((32'(i_ptr) + 32'(i)) % 32'(NUM_PORTS));
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_flow_arbiter.sv
// Round-robin output-port arbiter with RTS/DCTS handshake toward the next router.
// Build macro ARB_PKT_LOCK_EN: hold the grant until the tail flit (packet locking);
// undefined, the arbiter rotates after every flit and i_tail is unused.
module rr_flow_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [NUM_PORTS-1:0] i_tail,
  input  logic                 i_dcts,
  output logic [NUM_PORTS-1:0] o_grant,
  output logic [NUM_PORTS-1:0] o_xbar_sel,
  output logic                 o_rts,
  output logic                 o_busy
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic [IDX_W-1:0]     r_owner;
  logic [IDX_W-1:0]     r_ptr;
  logic                 r_rts;
  logic                 w_xfer_tail;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic [IDX_W-1:0]     w_pick_ptr;
  logic [IDX_W-1:0]     w_winner;
  logic                 w_pick_valid;
  logic                 w_rearb;
  logic                 w_xfer;
  logic [NUM_PORTS-1:0] w_owner_oh;

  assign w_ptr_inc  = (r_owner == IDX_W'(NUM_PORTS - 1)) ? '0 : r_owner + 1'b1;
  assign w_rearb    = (r_state == GAP) && w_xfer_tail;
  // On a packet boundary the rotated pointer must already steer this cycle's pick.
  assign w_pick_ptr = w_rearb ? w_ptr_inc : r_ptr;
  assign w_xfer     = (r_state == SEND) && r_rts && i_dcts;
  assign w_owner_oh = NUM_PORTS'(1) << r_owner;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (w_pick_ptr),
    .o_winner (w_winner),
    .o_valid  (w_pick_valid)
  );

`ifdef ARB_PKT_LOCK_EN
  logic r_xfer_tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_tail <= 1'b0;
    end else if (w_xfer) begin
      r_xfer_tail <= i_tail[r_owner];
    end
  end

  assign w_xfer_tail = r_xfer_tail;
`else
  logic w_unused_tail;

  assign w_xfer_tail   = 1'b1;
  assign w_unused_tail = ^i_tail;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rts   <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rts   <= (w_state_nxt == SEND);
      if (((r_state == IDLE) || w_rearb) && w_pick_valid) begin
        r_owner <= w_winner;
      end
      if (w_rearb) begin
        r_ptr <= w_ptr_inc;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_state_nxt = SEND;
      end
      SEND: begin
        if (w_xfer) w_state_nxt = GAP;
      end
      GAP: begin
        if (w_xfer_tail) begin
          w_state_nxt = w_pick_valid ? SEND : IDLE;
        end else if (i_req[r_owner]) begin
          w_state_nxt = SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_rts      = r_rts;
    o_grant    = (w_xfer && !rst) ? w_owner_oh : '0;
    o_busy     = !rst && (r_state != IDLE);
    o_xbar_sel = o_busy ? w_owner_oh : '0;
  end

endmodule

// File: tb/tb_rr_flow_arbiter.sv
// Randomised bench for rr_flow_arbiter: a 5-port and a 3-port instance run
// against a transaction-level arbitration model, plus directed scenarios.
module tb_rr_flow_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req5 = '0, tail5 = '0;
  logic       dcts = 1'b0;
  logic [4:0] grant5, xbar5;
  logic       rts5, busy5;
  logic [2:0] grant3, xbar3;
  logic       rts3, busy3;

  int n_checks = 0;
  int n_errors = 0;

  int np[2] = '{5, 3};
  int m_phase[2];      // 0: nobody held, 1: offering a flit, 2: one-cycle pause
  int m_owner[2];
  int m_ptr[2];
  bit m_last_tail[2];
  bit rts_known = 1'b0;

  always #5 clk = ~clk;

  rr_flow_arbiter #(.NUM_PORTS(5)) dut5 (
    .clk(clk), .rst(rst), .i_req(req5), .i_tail(tail5), .i_dcts(dcts),
    .o_grant(grant5), .o_xbar_sel(xbar5), .o_rts(rts5), .o_busy(busy5)
  );

  rr_flow_arbiter #(.NUM_PORTS(3)) dut3 (
    .clk(clk), .rst(rst), .i_req(req5[2:0]), .i_tail(tail5[2:0]), .i_dcts(dcts),
    .o_grant(grant3), .o_xbar_sel(xbar3), .o_rts(rts3), .o_busy(busy3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input int k, input logic [4:0] r);
    for (int i = 0; i < np[k]; i++) begin
      int p = (m_ptr[k] + i) % np[k];
      if (r[p]) return p;
    end
    return -1;
  endfunction

  function automatic int oh_index(input logic [4:0] v);
    int idx = -1;
    for (int j = 0; j < 5; j++) if (v[j]) idx = j;
    return idx;
  endfunction

  // One clock: drive inputs, compare all outputs of both instances, advance the model.
  task automatic step(input logic [4:0] r, input logic [4:0] t, input logic d, input logic s,
                      output logic [4:0] dut_grant);
    @(negedge clk);
    req5 = r; tail5 = t; dcts = d; rst = s;
    #1;
    dut_grant = grant5;
    for (int k = 0; k < 2; k++) begin
      logic [4:0] rk = (k == 0) ? r : (r & 5'b00111);
      logic [31:0] oh = 32'(1) << m_owner[k];
      logic [31:0] g_got = (k == 0) ? 32'(grant5) : 32'(grant3);
      logic [31:0] x_got = (k == 0) ? 32'(xbar5) : 32'(xbar3);
      logic b_got = (k == 0) ? busy5 : busy3;
      logic r_got = (k == 0) ? rts5 : rts3;
      int w;
      chk(k == 0 ? "grant5" : "grant3", g_got, (!s && m_phase[k] == 1 && d) ? oh : 32'd0);
      chk(k == 0 ? "xbar5" : "xbar3", x_got, (!s && m_phase[k] != 0) ? oh : 32'd0);
      chk(k == 0 ? "busy5" : "busy3", 32'(b_got), 32'(!s && m_phase[k] != 0));
      if (rts_known) chk(k == 0 ? "rts5" : "rts3", 32'(r_got), 32'(m_phase[k] == 1));
      if (s) begin
        m_phase[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_last_tail[k] = 1'b0;
      end else begin
        case (m_phase[k])
          0: begin
            w = pick(k, rk);
            if (w >= 0) begin m_owner[k] = w; m_phase[k] = 1; end
          end
          1: if (d) begin
`ifdef ARB_PKT_LOCK_EN
            m_last_tail[k] = ((k == 0) ? t[m_owner[k]] : (t[m_owner[k]] && m_owner[k] < 3));
`else
            m_last_tail[k] = 1'b1;
`endif
            m_phase[k] = 2;
          end
          default: begin
            if (!m_last_tail[k]) begin
              if (rk[m_owner[k]]) m_phase[k] = 1;
            end else begin
              m_ptr[k] = (m_owner[k] + 1) % np[k];
              w = pick(k, rk);
              if (w >= 0) begin m_owner[k] = w; m_phase[k] = 1; end
              else m_phase[k] = 0;
            end
          end
        endcase
      end
    end
    if (s) rts_known = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] g;
    int cnt;
    int order[$];
    int exp_fair[6] = '{0, 1, 2, 3, 4, 0};

    // Reset then idle
    repeat (2) step(5'b0, 5'b0, 1'b1, 1'b1, g);
    repeat (6) step(5'b0, 5'b0, 1'b1, 1'b0, g);

    // Three-flit packet on port W, tail on the third flit
    cnt = 0;
    for (int c = 0; c < 30 && cnt < 3; c++) begin
      step(5'b00100, (cnt == 2) ? 5'b00100 : 5'b0, 1'b1, 1'b0, g);
      if (g == 5'b00100) cnt++;
    end
    chk("pkt_w_grants", 32'(cnt), 32'd3);
    repeat (3) step(5'b0, 5'b0, 1'b1, 1'b0, g);

    // Backpressure on port N: rts held across the whole stall
    cnt = 0;
    step(5'b00001, 5'b00001, 1'b0, 1'b0, g);
    repeat (7) begin
      step(5'b00001, 5'b00001, 1'b0, 1'b0, g);
      if (rts5) cnt++;
    end
    step(5'b00001, 5'b00001, 1'b1, 1'b0, g);
    if (rts5) cnt++;
    chk("bp_grant", 32'(g), 32'h1);
    chk("bp_rts_cycles", 32'(cnt), 32'd8);
    repeat (2) step(5'b0, 5'b0, 1'b1, 1'b0, g);

    // Fairness: everybody requests single-flit packets
    step(5'b0, 5'b0, 1'b1, 1'b1, g);
    repeat (14) begin
      step(5'b11111, 5'b11111, 1'b1, 1'b0, g);
      if (g != 0) order.push_back(oh_index(g));
    end
    chk("fair_count", 32'(order.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < order.size(); i++) chk("fair_order", 32'(order[i]), 32'(exp_fair[i]));

`ifdef ARB_PKT_LOCK_EN
    // Port S holds the link until its tail, then E wins over an idle L
    order.delete();
    step(5'b0, 5'b0, 1'b1, 1'b1, g);
    for (int s = 0; s < 9; s++) begin
      step((s < 2) ? 5'b01000 : 5'b01010, (s >= 4) ? 5'b01010 : 5'b0, 1'b1, 1'b0, g);
      if (g != 0) order.push_back(oh_index(g));
    end
    chk("lock_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("lock_s0", 32'(order[0]), 32'd3);
      chk("lock_s1", 32'(order[1]), 32'd3);
      chk("lock_s2", 32'(order[2]), 32'd3);
      chk("lock_e", 32'(order[3]), 32'd1);
    end
`endif

    // Reset while offering a flit with dcts high
    step(5'b0, 5'b0, 1'b1, 1'b1, g);
    step(5'b00001, 5'b00001, 1'b1, 1'b0, g);
    step(5'b00001, 5'b00001, 1'b1, 1'b1, g);
    chk("grant_in_rst", 32'(g), 32'd0);
    step(5'b0, 5'b0, 1'b1, 1'b0, g);
    chk("rts_after_rst", 32'(rts5), 32'd0);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] r = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
      logic [4:0] t = 5'($urandom_range(0, 31));
      step(r, t, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0), g);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
